// File: rtl/clock_pkg.sv
// Shared types and constants for the clock user-input and display side.
// Field arithmetic helpers keep minute/second values inside 0..FIELD_MAX.
package clock_pkg;

   localparam int FW        = 7;
   localparam int FIELD_MAX = 59;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_MIN = 2'd1,
      SET_SEC = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   // digit_blank bit map: [3:2] minute digits, [1:0] second digits
   localparam logic [3:0] BLANK_NONE = 4'b0000;
   localparam logic [3:0] BLANK_MIN  = 4'b1100;
   localparam logic [3:0] BLANK_SEC  = 4'b0011;

   function automatic logic [FW-1:0] field_inc(input logic [FW-1:0] v);
      return (v >= FW'(FIELD_MAX)) ? '0 : v + FW'(1);
   endfunction

   function automatic logic [FW-1:0] field_dec(input logic [FW-1:0] v);
      return (v == '0 || v > FW'(FIELD_MAX)) ? FW'(FIELD_MAX) : v - FW'(1);
   endfunction

   function automatic logic [FW-1:0] field_clamp(input logic [FW-1:0] v);
      return (v > FW'(FIELD_MAX)) ? '0 : v;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stable-sample counter and press pulse.
// Level is accepted after DB_CYCLES equal samples; press pulse is one cycle on acceptance of a 1.
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int            CW      = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_press;
   logic          w_sample;

   assign w_sample = r_sync[1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync  <= 2'b00;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_btn};
         r_press <= 1'b0;
         // any sample matching the accepted level restarts the stability run
         if (w_sample == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_LAST) begin
            r_cnt   <= '0;
            r_level <= w_sample;
            r_press <= w_sample;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced mode/up/down buttons drive an MM:SS edit FSM.
// Holds time_gen while editing, pulses load on commit and drives the digit blink mask.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int DB_CYCLES    = 1_000_000,
   parameter int RPT_CYCLES   = 25_000_000,
   parameter int BLINK_CYCLES = 25_000_000
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_btn_mode,
   input  logic          i_btn_up,
   input  logic          i_btn_down,
   input  logic [FW-1:0] i_cur_min,
   input  logic [FW-1:0] i_cur_sec,
   output logic [FW-1:0] o_set_min,
   output logic [FW-1:0] o_set_sec,
   output logic          o_load,
   output logic          o_hold,
   output logic [3:0]    o_digit_blank
);

   localparam int             RCW      = $clog2(RPT_CYCLES + 1);
   localparam logic [RCW-1:0] RPT_LAST = RCW'(RPT_CYCLES - 1);
   localparam int             BCW      = $clog2(BLINK_CYCLES + 1);
   localparam logic [BCW-1:0] BLK_LAST = BCW'(BLINK_CYCLES - 1);

   logic w_mode_lvl, w_mode_p;
   logic w_up_lvl, w_up_p;
   logic w_dn_lvl, w_dn_p;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
      .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_mode), .o_level(w_mode_lvl), .o_press(w_mode_p)
   );
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
      .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_up), .o_level(w_up_lvl), .o_press(w_up_p)
   );
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
      .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_down), .o_level(w_dn_lvl), .o_press(w_dn_p)
   );

   state_t         r_state;
   state_t         w_state_nxt;
   logic [RCW-1:0] r_rpt_up_cnt, r_rpt_dn_cnt;
   logic           r_rpt_up, r_rpt_dn;
   logic [BCW-1:0] r_blk_cnt;
   logic           r_phase;
   logic [FW-1:0]  r_edit_min, r_edit_sec;
   logic [FW-1:0]  r_set_min, r_set_sec;
   logic           w_edit, w_nxt_edit, w_entry;
   logic           w_up_evt, w_dn_evt, w_inc, w_dec, w_step;

   // Repeat counters run whenever the level is high; the FSM decides whether a step applies.
   always_ff @(posedge i_clk) begin
      if (i_rst || !w_up_lvl) begin
         r_rpt_up_cnt <= '0;
         r_rpt_up     <= 1'b0;
      end else if (r_rpt_up_cnt == RPT_LAST) begin
         r_rpt_up_cnt <= '0;
         r_rpt_up     <= 1'b1;
      end else begin
         r_rpt_up_cnt <= r_rpt_up_cnt + 1'b1;
         r_rpt_up     <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || !w_dn_lvl) begin
         r_rpt_dn_cnt <= '0;
         r_rpt_dn     <= 1'b0;
      end else if (r_rpt_dn_cnt == RPT_LAST) begin
         r_rpt_dn_cnt <= '0;
         r_rpt_dn     <= 1'b1;
      end else begin
         r_rpt_dn_cnt <= r_rpt_dn_cnt + 1'b1;
         r_rpt_dn     <= 1'b0;
      end
   end

   assign w_edit   = (r_state == SET_MIN) || (r_state == SET_SEC);
   assign w_up_evt = w_up_p | r_rpt_up;
   assign w_dn_evt = w_dn_p | r_rpt_dn;
   // opposing steps cancel, and a mode press swallows any step in the same cycle
   assign w_inc    = w_edit && w_up_evt && !w_dn_evt && !w_mode_p;
   assign w_dec    = w_edit && w_dn_evt && !w_up_evt && !w_mode_p;
   assign w_step   = w_inc || w_dec;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      o_load        = 1'b0;
      o_hold        = 1'b1;
      o_digit_blank = BLANK_NONE;
      case (r_state)
         RUN: begin
            o_hold = 1'b0;
            if (w_mode_p) w_state_nxt = SET_MIN;
         end
         SET_MIN: begin
            o_digit_blank = BLANK_MIN & {4{r_phase}};
            if (w_mode_p) w_state_nxt = SET_SEC;
         end
         SET_SEC: begin
            o_digit_blank = BLANK_SEC & {4{r_phase}};
            if (w_mode_p) w_state_nxt = COMMIT;
         end
         COMMIT: begin
            o_load      = 1'b1;
            w_state_nxt = RUN;
         end
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_edit_min <= '0;
         r_edit_sec <= '0;
         r_set_min  <= '0;
         r_set_sec  <= '0;
      end else begin
         if (r_state == RUN && w_mode_p) begin
            r_edit_min <= field_clamp(i_cur_min);
            r_edit_sec <= field_clamp(i_cur_sec);
         end
         if (r_state == SET_MIN && w_inc) r_edit_min <= field_inc(r_edit_min);
         if (r_state == SET_MIN && w_dec) r_edit_min <= field_dec(r_edit_min);
         if (r_state == SET_SEC && w_inc) r_edit_sec <= field_inc(r_edit_sec);
         if (r_state == SET_SEC && w_dec) r_edit_sec <= field_dec(r_edit_sec);
         // committed values are latched on the way into COMMIT and held afterwards
         if (r_state == SET_SEC && w_mode_p) begin
            r_set_min <= r_edit_min;
            r_set_sec <= r_edit_sec;
         end
      end
   end

   assign w_nxt_edit = (w_state_nxt == SET_MIN) || (w_state_nxt == SET_SEC);
   assign w_entry    = (w_state_nxt != r_state);

   // Blink restarts visible on state entry and on each applied step so the user sees the new value.
   always_ff @(posedge i_clk) begin
      if (i_rst || !w_nxt_edit || w_entry || w_step) begin
         r_blk_cnt <= '0;
         r_phase   <= 1'b0;
      end else if (r_blk_cnt == BLK_LAST) begin
         r_blk_cnt <= '0;
         r_phase   <= ~r_phase;
      end else begin
         r_blk_cnt <= r_blk_cnt + 1'b1;
      end
   end

   assign o_set_min = r_set_min;
   assign o_set_sec = r_set_sec;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scenario bench for time_set_ctrl with short debounce, repeat and blink periods.
// Expected commits are queued when stimulus is driven and matched against each load pulse.
module tb_time_set_ctrl;
   import clock_pkg::*;

   localparam int DB  = 4;
   localparam int RPT = 20;
   localparam int BLK = 8;

   localparam logic [2:0] B_MODE = 3'b100;
   localparam logic [2:0] B_UP   = 3'b010;
   localparam logic [2:0] B_DN   = 3'b001;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          b_mode = 1'b0, b_up = 1'b0, b_dn = 1'b0;
   logic [FW-1:0] cur_min = '0, cur_sec = '0;
   logic [FW-1:0] o_set_min, o_set_sec;
   logic          o_load, o_hold;
   logic [3:0]    o_digit_blank;

   int            checks = 0;
   int            failures = 0;
   logic [13:0]   exp_q[$];
   logic [13:0]   mon_exp;

   always #5 clk = ~clk;

   time_set_ctrl #(.DB_CYCLES(DB), .RPT_CYCLES(RPT), .BLINK_CYCLES(BLK)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_btn_mode(b_mode), .i_btn_up(b_up), .i_btn_down(b_dn),
      .i_cur_min(cur_min), .i_cur_sec(cur_sec),
      .o_set_min(o_set_min), .o_set_sec(o_set_sec),
      .o_load(o_load), .o_hold(o_hold), .o_digit_blank(o_digit_blank)
   );

   // scoreboard: every load pulse consumes one expected MM:SS pair
   always @(negedge clk) begin
      if (!rst && o_load === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL load_unexpected got=%0d:%0d want=no load", o_set_min, o_set_sec);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({o_set_min, o_set_sec} !== mon_exp) begin
               failures++;
               $display("FAIL load_value got=%0d:%0d want=%0d:%0d",
                        o_set_min, o_set_sec, mon_exp[13:7], mon_exp[6:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [2:0] m, input int hi);
      {b_mode, b_up, b_dn} = m;
      idle(hi);
      {b_mode, b_up, b_dn} = 3'b000;
      idle(12);
   endtask

   task automatic commit(input int emin, input int esec);
      logic        found;
      logic [13:0] e;
      found = 1'b0;
      e = {7'(emin), 7'(esec)};
      exp_q.push_back(e);
      b_mode = 1'b1;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (o_load === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL commit_timeout load=0 want=1 within 40 cycles");
      end else begin
         checks++;
         if (o_hold !== 1'b1 || o_digit_blank !== 4'b0000) begin
            failures++;
            $display("FAIL commit_cycle hold=%b blank=%b want hold=1 blank=0000", o_hold, o_digit_blank);
         end
         @(negedge clk);
         checks++;
         if (o_load !== 1'b0 || o_hold !== 1'b0) begin
            failures++;
            $display("FAIL after_commit load=%b hold=%b want 0 0", o_load, o_hold);
         end
         checks++;
         if ({o_set_min, o_set_sec} !== e) begin
            failures++;
            $display("FAIL set_keep got=%0d:%0d want=%0d:%0d", o_set_min, o_set_sec, emin, esec);
         end
      end
      b_mode = 1'b0;
      idle(12);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(2);
      checks++; if (o_hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b want=0", o_hold); end
      checks++; if (o_load !== 1'b0) begin failures++; $display("FAIL reset_load got=%b want=0", o_load); end
      checks++; if (o_set_min !== '0) begin failures++; $display("FAIL reset_set_min got=%0d want=0", o_set_min); end
      checks++; if (o_set_sec !== '0) begin failures++; $display("FAIL reset_set_sec got=%0d want=0", o_set_sec); end
      checks++; if (o_digit_blank !== 4'b0000) begin failures++; $display("FAIL reset_blank got=%b want=0000", o_digit_blank); end
   endtask

   task automatic test_glitch();
      cur_min = 7'd5; cur_sec = 7'd6;
      b_mode = 1'b1;
      idle(3);
      b_mode = 1'b0;
      idle(15);
      checks++; if (o_hold !== 1'b0) begin failures++; $display("FAIL glitch_filtered hold=%b want=0", o_hold); end
      press(B_MODE, 10);
      checks++; if (o_hold !== 1'b1) begin failures++; $display("FAIL glitch_accepted hold=%b want=1", o_hold); end
      checks++; if (o_digit_blank[1:0] !== 2'b00) begin failures++; $display("FAIL set_min_sec_visible blank=%b want=xx00", o_digit_blank); end
      press(B_MODE, 10);
      commit(5, 6);
   endtask

   task automatic test_capture_commit();
      cur_min = 7'd12; cur_sec = 7'd34;
      press(B_MODE, 10);
      cur_min = 7'd50; cur_sec = 7'd50;
      press(B_UP, 10);
      press(B_UP, 10);
      press(B_MODE, 10);
      press(B_DN, 10);
      commit(14, 33);
   endtask

   task automatic test_wrap();
      cur_min = 7'd0; cur_sec = 7'd59;
      press(B_MODE, 10);
      press(B_MODE, 10);
      press(B_UP, 10);
      commit(0, 0);
      cur_min = 7'd0; cur_sec = 7'd0;
      press(B_MODE, 10);
      press(B_DN, 10);
      press(B_MODE, 10);
      press(B_DN, 10);
      commit(59, 59);
      cur_min = 7'd63; cur_sec = 7'd60;
      press(B_MODE, 10);
      press(B_MODE, 10);
      commit(0, 0);
   endtask

   task automatic test_autorepeat();
      cur_min = 7'd10; cur_sec = 7'd0;
      press(B_MODE, 10);
      press(B_UP, 2 + DB + 65);
      press(B_MODE, 10);
      commit(14, 0);
   endtask

   task automatic test_conflicts();
      cur_min = 7'd20; cur_sec = 7'd30;
      press(B_MODE, 10);
      press(B_UP | B_DN, 10);
      press(B_MODE | B_UP, 10);
      checks++; if (o_hold !== 1'b1) begin failures++; $display("FAIL conflict_hold hold=%b want=1", o_hold); end
      checks++; if (o_digit_blank[3:2] !== 2'b00) begin failures++; $display("FAIL set_sec_min_visible blank=%b want=00xx", o_digit_blank); end
      commit(20, 30);
   endtask

   task automatic test_reset_mid_edit();
      cur_min = 7'd7; cur_sec = 7'd8;
      press(B_MODE, 10);
      press(B_UP, 10);
      press(B_MODE, 10);
      press(B_UP, 10);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (o_hold !== 1'b0) begin failures++; $display("FAIL midreset_hold got=%b want=0", o_hold); end
      checks++; if (o_load !== 1'b0) begin failures++; $display("FAIL midreset_load got=%b want=0", o_load); end
      checks++; if ({o_set_min, o_set_sec} !== 14'd0) begin failures++; $display("FAIL midreset_set got=%0d:%0d want=0:0", o_set_min, o_set_sec); end
      checks++; if (o_digit_blank !== 4'b0000) begin failures++; $display("FAIL midreset_blank got=%b want=0000", o_digit_blank); end
      rst = 1'b0;
      idle(20);
      checks++; if (o_hold !== 1'b0) begin failures++; $display("FAIL midreset_stays_run hold=%b want=0", o_hold); end
   endtask

   task automatic test_blink();
      logic       found;
      logic       ph;
      logic [3:0] exp_b;
      found = 1'b0;
      cur_min = 7'd7; cur_sec = 7'd8;
      b_mode = 1'b1;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (o_hold === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL blink_entry_timeout hold=0 want=1 within 40 cycles");
      end else begin
         for (int k = 0; k < 3 * BLK; k++) begin
            ph = ((k / BLK) % 2) == 1;
            exp_b = {ph, ph, 2'b00};
            checks++;
            if (o_digit_blank !== exp_b) begin
               failures++;
               $display("FAIL blink_mask cycle=%0d got=%b want=%b", k, o_digit_blank, exp_b);
            end
            @(negedge clk);
         end
      end
      b_mode = 1'b0;
      idle(12);
      press(B_MODE, 10);
      commit(7, 8);
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_capture_commit();
      test_wrap();
      test_autorepeat();
      test_conflicts();
      test_reset_mid_edit();
      test_blink();
      idle(5);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_loads pending=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
